// File: rtl/rtt_stats.sv
// RX-path RTT statistics tap: forwards packet beats through one register stage and
// accumulates count/sum/min/max of the RTT carried in each packet's first beat.
module rtt_stats #(
    parameter int TIMESTAMP_WIDTH = 32,
    parameter int SUM_WIDTH       = 64,
    parameter int COUNT_WIDTH     = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [511:0]               in_pkt_data,
    input  logic                       in_pkt_valid,
    output logic                       in_pkt_ready,
    input  logic                       in_pkt_sop,
    input  logic                       in_pkt_eop,
    input  logic [5:0]                 in_pkt_empty,
    output logic [511:0]               out_pkt_data,
    output logic                       out_pkt_valid,
    input  logic                       out_pkt_ready,
    output logic                       out_pkt_sop,
    output logic                       out_pkt_eop,
    output logic [5:0]                 out_pkt_empty,
    input  logic                       conf_valid,
    input  logic                       conf_enable,
    input  logic [5:0]                 conf_offset,
    input  logic                       stats_req_valid,
    input  logic                       stats_req_clear,
    output logic                       stats_resp_valid,
    output logic [COUNT_WIDTH-1:0]     stats_count,
    output logic [SUM_WIDTH-1:0]       stats_sum,
    output logic [TIMESTAMP_WIDTH-1:0] stats_min,
    output logic [TIMESTAMP_WIDTH-1:0] stats_max
);

    localparam int TW = TIMESTAMP_WIDTH;
    localparam logic [9:0] TOP_BASE = 10'(512 - TW);
    localparam logic [9:0] TW_10    = 10'(TW);

    logic                   r_out_valid;
    logic [511:0]           r_out_data;
    logic                   r_out_sop;
    logic                   r_out_eop;
    logic [5:0]             r_out_empty;
    logic                   r_enable;
    logic [5:0]             r_offset;
    logic                   r_s_valid;
    logic [TW-1:0]          r_s_rtt;
    logic [COUNT_WIDTH-1:0] r_count;
    logic [SUM_WIDTH-1:0]   r_sum;
    logic [TW-1:0]          r_min;
    logic [TW-1:0]          r_max;
    logic                   r_resp_valid;
    logic [COUNT_WIDTH-1:0] r_stats_count;
    logic [SUM_WIDTH-1:0]   r_stats_sum;
    logic [TW-1:0]          r_stats_min;
    logic [TW-1:0]          r_stats_max;

    logic                   w_accept;
    logic                   w_off_ok;
    logic [9:0]             w_base;
    logic [TW-1:0]          w_rtt;
    logic [SUM_WIDTH:0]     w_sum_ext;
    logic [COUNT_WIDTH-1:0] w_count_nx;
    logic [SUM_WIDTH-1:0]   w_sum_nx;
    logic [TW-1:0]          w_min_nx;
    logic [TW-1:0]          w_max_nx;

    assign in_pkt_ready = !r_out_valid || out_pkt_ready;
    assign w_accept     = in_pkt_valid && in_pkt_ready;

    // Byte 0 sits at the MSB end, so the field's LSB index counts down from the top.
    assign w_off_ok  = ({1'b0, conf_offset, 3'b000} + TW_10) <= 10'd512;
    assign w_base    = TOP_BASE - {1'b0, r_offset, 3'b000};
    assign w_rtt     = TW'(in_pkt_data >> w_base);
    assign w_sum_ext = {1'b0, r_sum} + (SUM_WIDTH + 1)'(r_s_rtt);

    // Stats with the pending sample folded in; a snapshot reports these values.
    always_comb begin
        w_count_nx = r_count;
        w_sum_nx   = r_sum;
        w_min_nx   = r_min;
        w_max_nx   = r_max;
        if (r_s_valid) begin
            if (r_count != '1) w_count_nx = r_count + COUNT_WIDTH'(1);
            w_sum_nx = w_sum_ext[SUM_WIDTH] ? '1 : w_sum_ext[SUM_WIDTH-1:0];
            if (r_s_rtt < r_min) w_min_nx = r_s_rtt;
            if (r_s_rtt > r_max) w_max_nx = r_s_rtt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_out_sop     <= 1'b0;
            r_out_eop     <= 1'b0;
            r_out_empty   <= '0;
            r_enable      <= 1'b0;
            r_offset      <= '0;
            r_s_valid     <= 1'b0;
            r_s_rtt       <= '0;
            r_count       <= '0;
            r_sum         <= '0;
            r_min         <= '1;
            r_max         <= '0;
            r_resp_valid  <= 1'b0;
            r_stats_count <= '0;
            r_stats_sum   <= '0;
            r_stats_min   <= '0;
            r_stats_max   <= '0;
        end else begin
            if (in_pkt_ready) begin
                r_out_valid <= in_pkt_valid;
                if (in_pkt_valid) begin
                    r_out_data  <= in_pkt_data;
                    r_out_sop   <= in_pkt_sop;
                    r_out_eop   <= in_pkt_eop;
                    r_out_empty <= in_pkt_empty;
                end
            end

            r_s_valid <= w_accept && in_pkt_sop && r_enable;
            if (w_accept && in_pkt_sop) r_s_rtt <= w_rtt;

            if (conf_valid) begin
                r_enable <= conf_enable;
                if (w_off_ok) r_offset <= conf_offset;
            end

            r_resp_valid <= stats_req_valid;
            if (stats_req_valid) begin
                r_stats_count <= w_count_nx;
                r_stats_sum   <= w_sum_nx;
                r_stats_min   <= w_min_nx;
                r_stats_max   <= w_max_nx;
            end
            // A clearing snapshot consumes the pending sample, so it is not re-added.
            if (stats_req_valid && stats_req_clear) begin
                r_count <= '0;
                r_sum   <= '0;
                r_min   <= '1;
                r_max   <= '0;
            end else begin
                r_count <= w_count_nx;
                r_sum   <= w_sum_nx;
                r_min   <= w_min_nx;
                r_max   <= w_max_nx;
            end
        end
    end

    assign out_pkt_valid    = r_out_valid;
    assign out_pkt_data     = r_out_data;
    assign out_pkt_sop      = r_out_sop;
    assign out_pkt_eop      = r_out_eop;
    assign out_pkt_empty    = r_out_empty;
    assign stats_resp_valid = r_resp_valid;
    assign stats_count      = r_stats_count;
    assign stats_sum        = r_stats_sum;
    assign stats_min        = r_stats_min;
    assign stats_max        = r_stats_max;

endmodule

// File: tb/tb_rtt_stats.sv
// Bench for rtt_stats: directed scenarios plus a random phase, checked by a beat and
// snapshot scoreboard fed from a window-of-samples reference model.
module tb_rtt_stats;

    localparam int TW = 32;
    localparam int SW = 33;
    localparam int CW = 32;
    localparam longint unsigned SMAX = (64'd1 << SW) - 1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [511:0]   in_pkt_data = '0;
    logic           in_pkt_valid = 1'b0;
    logic           in_pkt_ready;
    logic           in_pkt_sop = 1'b0;
    logic           in_pkt_eop = 1'b0;
    logic [5:0]     in_pkt_empty = '0;
    logic [511:0]   out_pkt_data;
    logic           out_pkt_valid;
    logic           out_pkt_ready = 1'b1;
    logic           out_pkt_sop;
    logic           out_pkt_eop;
    logic [5:0]     out_pkt_empty;
    logic           conf_valid = 1'b0;
    logic           conf_enable = 1'b0;
    logic [5:0]     conf_offset = '0;
    logic           stats_req_valid = 1'b0;
    logic           stats_req_clear = 1'b0;
    logic           stats_resp_valid;
    logic [CW-1:0]  stats_count;
    logic [SW-1:0]  stats_sum;
    logic [TW-1:0]  stats_min;
    logic [TW-1:0]  stats_max;

    always #5 clk = ~clk;

    rtt_stats #(.TIMESTAMP_WIDTH(TW), .SUM_WIDTH(SW), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_pkt_data(in_pkt_data), .in_pkt_valid(in_pkt_valid), .in_pkt_ready(in_pkt_ready),
        .in_pkt_sop(in_pkt_sop), .in_pkt_eop(in_pkt_eop), .in_pkt_empty(in_pkt_empty),
        .out_pkt_data(out_pkt_data), .out_pkt_valid(out_pkt_valid), .out_pkt_ready(out_pkt_ready),
        .out_pkt_sop(out_pkt_sop), .out_pkt_eop(out_pkt_eop), .out_pkt_empty(out_pkt_empty),
        .conf_valid(conf_valid), .conf_enable(conf_enable), .conf_offset(conf_offset),
        .stats_req_valid(stats_req_valid), .stats_req_clear(stats_req_clear),
        .stats_resp_valid(stats_resp_valid), .stats_count(stats_count), .stats_sum(stats_sum),
        .stats_min(stats_min), .stats_max(stats_max)
    );

    typedef struct packed {
        logic [511:0] d;
        logic         s;
        logic         e;
        logic [5:0]   em;
    } beat_t;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [SW-1:0] s;
        logic [TW-1:0] mn;
        logic [TW-1:0] mx;
    } stat_t;

    int      n_cmp = 0;
    int      n_bad = 0;
    beat_t   exp_beats[$];
    stat_t   exp_resp[$];
    logic [TW-1:0] win[$];   // samples not yet reported by any snapshot
    bit      m_en = 0;
    int      m_off = 0;
    bit      acc = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic stat_t fold();
        stat_t r;
        longint unsigned sm = 0;
        r.c  = CW'(win.size());
        r.mn = '1;
        r.mx = '0;
        foreach (win[i]) begin
            sm += longint'(win[i]);
            if (sm > SMAX) sm = SMAX;
            if (win[i] < r.mn) r.mn = win[i];
            if (win[i] > r.mx) r.mx = win[i];
        end
        r.s = SW'(sm);
        return r;
    endfunction

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [511:0] mk(input logic [TW-1:0] rtt, input int off);
        logic [511:0] r;
        r = rnd512();
        r[(512 - TW - 8*off) +: TW] = rtt;
        return r;
    endfunction

    // Advance one clock; the model applies what the DUT will see at the coming edge.
    task automatic tick();
        @(negedge clk);
        acc = 0;
        if (!rst_n) begin
            win.delete();
            exp_beats.delete();
            exp_resp.delete();
            m_en  = 0;
            m_off = 0;
        end else begin
            if (stats_req_valid) begin
                exp_resp.push_back(fold());
                if (stats_req_clear) win.delete();
            end
            if (in_pkt_valid && in_pkt_ready) begin
                acc = 1;
                exp_beats.push_back('{in_pkt_data, in_pkt_sop, in_pkt_eop, in_pkt_empty});
                if (in_pkt_sop && m_en)
                    win.push_back(TW'(in_pkt_data >> (512 - TW - 8*m_off)));
            end
            if (conf_valid) begin
                m_en = conf_enable;
                if (int'(conf_offset) * 8 + TW <= 512) m_off = int'(conf_offset);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [511:0] d, input logic s, input logic e, input logic [5:0] em);
        in_pkt_data  = d;
        in_pkt_sop   = s;
        in_pkt_eop   = e;
        in_pkt_empty = em;
        in_pkt_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (acc) return;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL send_timeout: beat not accepted within 100 cycles");
    endtask

    task automatic idle();
        in_pkt_valid = 1'b0;
        tick();
    endtask

    task automatic req(input bit clr);
        in_pkt_valid    = 1'b0;
        stats_req_valid = 1'b1;
        stats_req_clear = clr;
        tick();
        stats_req_valid = 1'b0;
        stats_req_clear = 1'b0;
    endtask

    task automatic conf(input bit en, input int off);
        in_pkt_valid = 1'b0;
        conf_valid   = 1'b1;
        conf_enable  = en;
        conf_offset  = 6'(off);
        tick();
        conf_valid   = 1'b0;
    endtask

    task automatic chk_stats(input string nm, input logic [CW-1:0] c, input logic [SW-1:0] s,
                             input logic [TW-1:0] mn, input logic [TW-1:0] mx);
        chk({nm, "_count"}, 64'(stats_count), 64'(c));
        chk({nm, "_sum"},   64'(stats_sum),   64'(s));
        chk({nm, "_min"},   64'(stats_min),   64'(mn));
        chk({nm, "_max"},   64'(stats_max),   64'(mx));
    endtask

    // Monitor: beat and snapshot scoreboards, plus output stability under backpressure.
    beat_t hold_beat;
    bit    hold_pend = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pend = 0;
        end else begin
            beat_t cur;
            cur = '{out_pkt_data, out_pkt_sop, out_pkt_eop, out_pkt_empty};
            if (hold_pend) begin
                n_cmp++;
                if (!out_pkt_valid || cur !== hold_beat) begin
                    n_bad++;
                    $display("FAIL hold: valid=%0b data_lo=%0h expected valid=1 data_lo=%0h",
                             out_pkt_valid, cur.d[63:0], hold_beat.d[63:0]);
                end
            end
            hold_pend = out_pkt_valid && !out_pkt_ready;
            hold_beat = cur;
            if (out_pkt_valid && out_pkt_ready) begin
                n_cmp++;
                if (exp_beats.size() == 0) begin
                    n_bad++;
                    $display("FAIL beat_extra: got beat data_lo=%0h expected none", cur.d[63:0]);
                end else begin
                    beat_t e;
                    e = exp_beats.pop_front();
                    if (cur !== e) begin
                        n_bad++;
                        $display("FAIL beat: got sop=%0b eop=%0b empty=%0d data_lo=%0h expected sop=%0b eop=%0b empty=%0d data_lo=%0h",
                                 cur.s, cur.e, cur.em, cur.d[63:0], e.s, e.e, e.em, e.d[63:0]);
                    end
                end
            end
            if (stats_resp_valid) begin
                n_cmp++;
                if (exp_resp.size() == 0) begin
                    n_bad++;
                    $display("FAIL resp_extra: got count=%0d expected no response", stats_count);
                end else begin
                    stat_t e;
                    e = exp_resp.pop_front();
                    if (stats_count !== e.c || stats_sum !== e.s || stats_min !== e.mn || stats_max !== e.mx) begin
                        n_bad++;
                        $display("FAIL resp: got count=%0d sum=%0h min=%0h max=%0h expected count=%0d sum=%0h min=%0h max=%0h",
                                 stats_count, stats_sum, stats_min, stats_max, e.c, e.s, e.mn, e.mx);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] d;
        int left;

        // Reset state
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_out_valid", 64'(out_pkt_valid), 64'd0);
        chk("rst_resp_valid", 64'(stats_resp_valid), 64'd0);
        chk_stats("rst", '0, '0, '0, '0);
        rst_n = 1'b1;
        tick();

        // Three single-beat packets at offset 18, back to back
        conf(1, 18);
        d = mk(32'd21, 18);
        send(d, 1, 1, 6'd3);
        chk("lat_valid", 64'(out_pkt_valid), 64'd1);
        chk("lat_data", 64'(out_pkt_data === d), 64'd1);
        send(mk(32'd5, 18), 1, 1, 6'd0);
        send(mk(32'd40, 18), 1, 1, 6'd63);
        idle();
        req(0);
        idle();
        chk_stats("basic", 32'd3, 33'd66, 32'd5, 32'd40);

        // 4-beat packet with a 10-cycle stall in the middle
        send(mk(32'd100, 18), 1, 0, 6'd0);
        send(rnd512(), 0, 0, 6'd0);
        out_pkt_ready = 1'b0;
        d = rnd512();
        in_pkt_data  = d;
        in_pkt_sop   = 1'b0;
        in_pkt_eop   = 1'b0;
        in_pkt_valid = 1'b1;
        repeat (10) tick();
        out_pkt_ready = 1'b1;
        send(d, 0, 0, 6'd0);
        send(rnd512(), 0, 1, 6'd17);
        idle();
        req(0);
        idle();
        chk_stats("stall", 32'd4, 33'd166, 32'd5, 32'd100);

        // Clearing request while a sample is pending
        req(1);
        send(mk(32'd7, 18), 1, 1, 6'd0);
        req(1);
        idle();
        chk_stats("clr_pend", 32'd1, 33'd7, 32'd7, 32'd7);
        req(0);
        idle();
        chk_stats("clr_after", 32'd0, 33'd0, 32'hFFFF_FFFF, 32'd0);

        // Out-of-range offset keeps offset 18
        conf(1, 62);
        send(mk(32'd11, 18), 1, 1, 6'd0);
        req(1);
        idle();
        chk_stats("bad_off", 32'd1, 33'd11, 32'd11, 32'd11);

        // Sampling disabled
        conf(0, 18);
        for (int i = 0; i < 5; i++) send(mk(32'(i + 1), 18), 1, 1, 6'd0);
        req(0);
        idle();
        chk_stats("disabled", 32'd0, 33'd0, 32'hFFFF_FFFF, 32'd0);

        // Reset mid-packet drops the beat and the captured sample
        conf(1, 18);
        send(mk(32'd9, 18), 1, 1, 6'd0);
        req(0);
        send(mk(32'd3, 18), 1, 0, 6'd0);
        in_pkt_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        chk("mid_rst_out_valid", 64'(out_pkt_valid), 64'd0);
        chk_stats("mid_rst", '0, '0, '0, '0);
        rst_n = 1'b1;
        req(0);
        idle();
        chk_stats("post_rst", 32'd0, 33'd0, 32'hFFFF_FFFF, 32'd0);

        // Sum saturation
        conf(1, 18);
        for (int i = 0; i < 3; i++) send(mk(32'hFFFF_FFFF, 18), 1, 1, 6'd0);
        req(1);
        idle();
        chk_stats("sat", 32'd3, 33'h1_FFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // Random traffic, backpressure, requests and reconfiguration
        left = 0;
        in_pkt_valid = 1'b0;
        acc = 0;
        repeat (400) begin
            if (!in_pkt_valid || acc) begin
                if ($urandom_range(0, 9) < 7) begin
                    if (left == 0) begin
                        left = $urandom_range(1, 4);
                        in_pkt_sop  = 1'b1;
                        in_pkt_data = mk(TW'($urandom), m_off);
                    end else begin
                        in_pkt_sop  = 1'b0;
                        in_pkt_data = rnd512();
                    end
                    in_pkt_eop   = (left == 1);
                    in_pkt_empty = (left == 1) ? 6'($urandom_range(0, 63)) : 6'd0;
                    left--;
                    in_pkt_valid = 1'b1;
                end else begin
                    in_pkt_valid = 1'b0;
                end
            end
            out_pkt_ready   = ($urandom_range(0, 3) != 0);
            stats_req_valid = ($urandom_range(0, 9) == 0);
            stats_req_clear = ($urandom_range(0, 2) == 0);
            conf_valid      = ($urandom_range(0, 29) == 0);
            conf_enable     = ($urandom_range(0, 4) != 0);
            conf_offset     = 6'($urandom_range(0, 63));
            tick();
        end

        // Drain and a final snapshot
        stats_req_valid = 1'b0;
        stats_req_clear = 1'b0;
        conf_valid      = 1'b0;
        out_pkt_ready   = 1'b1;
        in_pkt_valid    = 1'b0;
        repeat (3) tick();
        req(1);
        for (int k = 0; k < 20 && (exp_beats.size() != 0 || exp_resp.size() != 0); k++) tick();
        chk("drain_beats", 64'(exp_beats.size()), 64'd0);
        chk("drain_resp", 64'(exp_resp.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
